sdram_arbiter: RTL
==================

# sdram_arbiter

Two-port Avalon-MM arbiter that shares the single SDRAM controller slave between two requesters: port 0 (video scan-out reader) and port 1 (Nios/draw-engine writer). Fair round-robin arbitration per accepted command. Read responses from the pipelined controller are routed back to the issuing port using an in-order tag FIFO. Sits between the requester masters and the SDRAM controller `s1` port inside the EDL_Final system.

## Interface

Parameters:
- `ADDR_W`, 24: word address width (32 MB x16 SDRAM).
- `DATA_W`, 16: data width; byteenable width is `DATA_W/8`.
- `MAX_PENDING`, 4: maximum outstanding reads; a power of 2, at least 2.

Ports:
- `clk_clk` in 1: single clock for all logic.
- `reset_reset_n` in 1: asynchronous, active-low reset.
- `pN_address` in ADDR_W: port N word address (N = 0, 1; the same set exists per port).
- `pN_read`, `pN_write` in 1: port N command. Both asserted together is illegal.
- `pN_writedata` in DATA_W; `pN_byteenable` in DATA_W/8.
- `pN_waitrequest` out 1: high unless port N's command is accepted this cycle.
- `pN_readdata` out DATA_W: broadcast of `m_readdata`.
- `pN_readdatavalid` out 1: read response for port N.
- `m_address` out ADDR_W; `m_read`, `m_write` out 1; `m_writedata` out DATA_W; `m_byteenable` out DATA_W/8: toward the controller.
- `m_waitrequest` in 1; `m_readdata` in DATA_W; `m_readdatavalid` in 1: from the controller.

## Operation

- **Request detection.** `reqN = pN_write | (pN_read & !fifo_full)`. A read is never eligible while the tag FIFO holds `MAX_PENDING` entries, even if a pop happens in the same cycle.
- **Grant, when `locked` = 0.**
  - If only one port requests, that port is granted.
  - If both request, the port other than `last_grant` is granted.
  - If neither requests, `m_read` and `m_write` are 0 and the other master outputs are don't-care.
- **Grant, when `locked` = 1.** Grant is `locked_id`, whatever else is requesting.
- **Command path.** The master command/address/data outputs are muxed combinationally from the granted port.
- **Accept.** `accept = (m_read | m_write) & !m_waitrequest`.
  - Granted port's `pN_waitrequest` = `m_waitrequest`.
  - Non-granted port's `pN_waitrequest` = 1.
- **Lock.** Required so Avalon command-hold is honoured across arbitration.
  - Set `locked` and `locked_id` = grant when a command is presented and `m_waitrequest` = 1.
  - Clear `locked` on accept.
- **Round-robin pointer.** On accept, `last_grant` <= granted port.
- **Tag FIFO (push).** An accepted read pushes the granted port ID.
- **Tag FIFO (pop).** `m_readdatavalid` pops the head entry and asserts `pN_readdatavalid` for the head ID only.
  - Push and pop in the same cycle leave the count unchanged.
  - Pop on an empty FIFO is ignored; the simulation assertion fires.
- **Writes** never touch the FIFO. A write may be accepted while reads are outstanding, since the controller keeps order.
- **Reset values.** `locked` = 0, `last_grant` = 1 (port 0 wins the first tie), FIFO empty with count 0.
  - With inputs idle after reset: `m_read` = `m_write` = 0, `pN_waitrequest` = 1, `pN_readdatavalid` = 0.
- **Reset mid-operation.** Outstanding tags are discarded. Responses arriving later are dropped, with no `pN_readdatavalid`.

## Timing

- Arbitration and command forwarding are combinational, with zero added cycles. Accept occurs in the same cycle as `m_waitrequest` = 0.
- Read response routing is combinational: `pN_readdatavalid` is valid in the same cycle as `m_readdatavalid`.
- Lock, pointer and FIFO state update on the rising edge of `clk_clk`.
- Sustained throughput is one command per cycle when `m_waitrequest` = 0.
- With both ports continuously requesting, accepted commands alternate 0,1,0,1.
- The count uses a `$clog2(MAX_PENDING)+1`-bit counter. FIFO pointers are `$clog2(MAX_PENDING)` bits and wrap naturally.

## Structure

- **Package `sdram_arb_pkg`** holds:
  - `NUM_PORTS` = 2
  - `port_id_t` (1 bit)
  - `PORT_VIDEO` = 0, `PORT_CPU` = 1
- **Sub-module `sdram_arb_tag_fifo`:** synchronous FIFO of `port_id_t`, parameter `DEPTH`.
  - Inputs: `push`, `pop`, `din`.
  - Outputs: `head`, `full`, `empty`, `count`.
  - Uses the same clock/reset names.
- The top level holds the grant/lock logic and the muxes.

## Test plan

1. **Reset, then single read.** Hold `reset_reset_n` = 0 and check all outputs hold their reset values; release. Port 0 reads address 0x000010 with `m_waitrequest` = 0 → `m_read` = 1 with `m_address` = 0x000010 that cycle. A `m_readdatavalid` with 0xBEEF 3 cycles later → `p0_readdatavalid` = 1, `p0_readdata` = 0xBEEF, `p1_readdatavalid` = 0.
2. **Simultaneous requests.** Both ports write continuously for 6 accepts → accept order is 0,1,0,1,0,1. The losing port sees `pN_waitrequest` = 1 on every cycle it loses.
3. **Lock under stall.** Port 1 writes 0x1234 to 0x00ABCD while `m_waitrequest` = 1 for 4 cycles; port 0 raises a read in cycle 2 → the master outputs stay on port 1 unchanged until accept. Port 0 is granted the next cycle.
4. **FIFO full.** Port 0 issues 5 back-to-back reads with no responses and `MAX_PENDING` = 4 → 4 are accepted and the 5th holds `p0_waitrequest` = 1. A port 1 write is still accepted. The 5th read is accepted the cycle after the first `m_readdatavalid`.
5. **Interleaved reads.** Port 0, then port 1, then port 0 each read; the 3 responses return in order → `readdatavalid` pulses go to ports 0, 1, 0. One response coincides with a new push, and the count must remain consistent.
6. **Reset with 2 reads outstanding.** Assert reset, release, then inject a stray `m_readdatavalid` → no `pN_readdatavalid` pulse, the FIFO remains empty, and the assertion is logged.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared types for the two-port SDRAM arbiter: port IDs and the round-robin pick.
package sdram_arb_pkg;
  localparam int NUM_PORTS = 2;

  typedef logic port_id_t;

  localparam port_id_t PORT_VIDEO = 1'b0;
  localparam port_id_t PORT_CPU   = 1'b1;

  // On a tie the port that did not win last time goes next.
  function automatic port_id_t rr_pick(input logic [NUM_PORTS-1:0] req, input port_id_t last);
    if (&req) return ~last;
    return req[PORT_CPU] ? PORT_CPU : PORT_VIDEO;
  endfunction
endpackage

// File: rtl/sdram_arb_tag_fifo.sv
// In-order FIFO of issuing port IDs; one entry per read accepted by the controller.
module sdram_arb_tag_fifo
  import sdram_arb_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk_clk,
  input  logic          reset_reset_n,
  input  logic          push,
  input  logic          pop,
  input  port_id_t      din,
  output port_id_t      head,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);
  port_id_t      mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (count == DEPTH[AW:0]);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      // A response with no tag (e.g. after a reset mid-burst) is dropped.
      assert (!(pop && empty)) else $warning("sdram_arb_tag_fifo: response with no outstanding tag dropped");
    end
  end

  always_ff @(posedge clk_clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller slave between video (port 0) and CPU (port 1).
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W      = 24,
  parameter int DATA_W      = 16,
  parameter int MAX_PENDING = 4
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  input  logic [ADDR_W-1:0]   p0_address,
  input  logic                p0_read,
  input  logic                p0_write,
  input  logic [DATA_W-1:0]   p0_writedata,
  input  logic [DATA_W/8-1:0] p0_byteenable,
  output logic                p0_waitrequest,
  output logic [DATA_W-1:0]   p0_readdata,
  output logic                p0_readdatavalid,
  input  logic [ADDR_W-1:0]   p1_address,
  input  logic                p1_read,
  input  logic                p1_write,
  input  logic [DATA_W-1:0]   p1_writedata,
  input  logic [DATA_W/8-1:0] p1_byteenable,
  output logic                p1_waitrequest,
  output logic [DATA_W-1:0]   p1_readdata,
  output logic                p1_readdatavalid,
  output logic [ADDR_W-1:0]   m_address,
  output logic                m_read,
  output logic                m_write,
  output logic [DATA_W-1:0]   m_writedata,
  output logic [DATA_W/8-1:0] m_byteenable,
  input  logic                m_waitrequest,
  input  logic [DATA_W-1:0]   m_readdata,
  input  logic                m_readdatavalid
);
  localparam int BE_W  = DATA_W/8;
  localparam int CNT_W = $clog2(MAX_PENDING) + 1;

  logic [NUM_PORTS-1:0]             rd, wr, req, port_wait, rdv;
  logic [NUM_PORTS-1:0][ADDR_W-1:0] addr;
  logic [NUM_PORTS-1:0][DATA_W-1:0] wdata;
  logic [NUM_PORTS-1:0][BE_W-1:0]   be;

  logic       locked, cmd_vld, accept;
  port_id_t   locked_id, last_grant, grant;
  logic       fifo_full, fifo_empty;
  port_id_t   fifo_head;
  logic [CNT_W-1:0] fifo_count;

  assign rd    = {p1_read, p0_read};
  assign wr    = {p1_write, p0_write};
  assign addr  = {p1_address, p0_address};
  assign wdata = {p1_writedata, p0_writedata};
  assign be    = {p1_byteenable, p0_byteenable};

  // Reads become ineligible as soon as the tag FIFO is full, even if a pop is in flight.
  assign req     = wr | (rd & {NUM_PORTS{~fifo_full}});
  assign grant   = locked ? locked_id : rr_pick(req, last_grant);
  assign cmd_vld = locked | req[grant];

  assign m_read       = cmd_vld & rd[grant];
  assign m_write      = cmd_vld & wr[grant];
  assign m_address    = addr[grant];
  assign m_writedata  = wdata[grant];
  assign m_byteenable = be[grant];
  assign accept       = (m_read | m_write) & ~m_waitrequest;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    assign port_wait[i] = ~(cmd_vld && grant == port_id_t'(i)) | m_waitrequest;
    assign rdv[i]       = m_readdatavalid & ~fifo_empty & (fifo_head == port_id_t'(i));
  end

  assign p0_waitrequest   = port_wait[PORT_VIDEO];
  assign p1_waitrequest   = port_wait[PORT_CPU];
  assign p0_readdatavalid = rdv[PORT_VIDEO];
  assign p1_readdatavalid = rdv[PORT_CPU];
  assign p0_readdata      = m_readdata;
  assign p1_readdata      = m_readdata;

  // A stalled command pins the grant so the master's held command is never swapped out.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      locked     <= 1'b0;
      locked_id  <= PORT_VIDEO;
      last_grant <= PORT_CPU;
    end else begin
      if (accept) begin
        locked     <= 1'b0;
        last_grant <= grant;
      end else if (m_read | m_write) begin
        locked    <= 1'b1;
        locked_id <= grant;
      end
      assert (fifo_count <= CNT_W'(MAX_PENDING)) else $error("sdram_arbiter: tag count overflow");
    end
  end

  sdram_arb_tag_fifo #(.DEPTH(MAX_PENDING)) u_tag_fifo (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .push          (accept & m_read),
    .pop           (m_readdatavalid),
    .din           (grant),
    .head          (fifo_head),
    .full          (fifo_full),
    .empty         (fifo_empty),
    .count         (fifo_count)
  );
endmodule
